audio_sample_cache: RTL and testbench
=====================================

Name: audio_sample_cache

Overview:
- Parametrised per-channel line cache between the audio mixer's channel sequencer and the SDRAM burst-read port.
- Holds one line of LINE_WORDS 32-bit words per channel, each with its own tag and valid bit.
- Serves 8-bit or 16-bit samples, expanded to 16 bits, one cycle after a hit.
- On a miss it issues one line burst, tagged with the requesting channel, and the requester retries until it hits. The block also supports per-channel invalidation.

Parameters:
- NUM_CHANNELS, 8, number of audio channels (power of two, 2..32); CW = clog2(NUM_CHANNELS).
- LINE_WORDS, 16, 32-bit words per line (power of two, 4..64); OB = clog2(LINE_WORDS)+2 byte-offset bits.
- ADDR_WIDTH, 26, byte address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mem_request  in  1  sample read request this cycle
- mem_address  in  ADDR_WIDTH  byte address of sample
- mem_channel  in  CW  requesting channel
- mem_mode16  in  1  1 = 16-bit sample, 0 = 8-bit sample
- mem_valid  out  1  mem_data valid (one-cycle pulse)
- mem_data  out  16  sample data
- mem_miss  out  1  pulse: request missed, retry later
- invalidate  in  1  clear valid bit of inv_channel
- inv_channel  in  CW  channel to invalidate
- busy  out  1  line fill outstanding
- sdram_request  out  1  burst read request
- sdram_ready  in  1  SDRAM accepts request
- sdram_address  out  ADDR_WIDTH  line-aligned burst address
- sdram_rvalid  in  1  read word valid
- sdram_raddress  in  ADDR_WIDTH  address of read word
- sdram_rdata  in  32  read word
- sdram_complete  in  1  burst finished

Behaviour:
- Reset: mem_valid=0, mem_miss=0, mem_data=0, sdram_request=0, sdram_address=0, busy=0, all valid bits=0, FSM=IDLE. Reset mid-fill abandons the fill; later rvalid/complete from the stale burst are ignored because the FSM is in IDLE.
- Hit condition: mem_request && valid[mem_channel] && tag[mem_channel] == mem_address[ADDR_WIDTH-1:OB].
- Hit latency: mem_valid=1 the next cycle, with mem_data extracted from word mem_address[OB-1:2] of that channel's line.
  - 8-bit mode: byte selected by address[1:0], replicated into both halves ({b,b}).
  - 16-bit mode: halfword selected by address[1]; address[0] is ignored.
- mem_data holds its last value when mem_valid=0.
- Miss: mem_miss=1 the next cycle and mem_valid=0.
  - If FSM=IDLE: latch fill_ch=mem_channel and fill_tag; clear valid[fill_ch]; sdram_address = address with low OB bits zero; sdram_request=1; go to REQ.
  - If FSM is not IDLE: no new fill is started.
- FSM:
  - IDLE → REQ on a miss.
  - REQ: sdram_request is held high until sampled with sdram_ready=1. It is then deasserted next cycle and the FSM goes to FILL.
  - FILL: each sdram_rvalid writes sdram_rdata to line[fill_ch][sdram_raddress[OB-1:2]]. sdram_complete sets tag[fill_ch]=fill_tag, sets valid[fill_ch]=1 unless the fill was dropped, and returns to IDLE.
  - sdram_rvalid and sdram_complete outside FILL are ignored.
- busy = (FSM != IDLE).
- Hits on other channels are served normally during REQ/FILL. Requests for fill_ch during a fill miss, because its valid bit is clear.
- Invalidate: valid[inv_channel] is cleared next cycle.
  - If inv_channel == fill_ch during REQ/FILL, set the drop flag: the fill still completes, but valid is not set.
  - Invalidate has priority over a same-cycle hit on that channel; that request is reported as a miss.
- Simultaneous sdram_complete and a miss request: the FSM returns to IDLE this cycle; the new miss is not accepted until the following request.
- Line storage: NUM_CHANNELS*LINE_WORDS x 32 array, registered read (inferable as block RAM). Write and read of the same word in one cycle return the old data; hits to a filling line are impossible by construction.

Test Plan:
- Reset → all outputs 0; first request ch0 addr 0x000040, 8-bit → mem_miss=1 next cycle, sdram_request=1, sdram_address=0x000040 (defaults).
- Complete burst of 16 words (word k = 0x03020100 + k*0x04040404) via fill, then request ch0 0x000045 8-bit → mem_valid next cycle, mem_data=0x0505.
- Same line, 16-bit mode, addr 0x000046 → mem_data=0x0706; addr 0x000047 → 0x0706.
- Ch1 fill at 0x001000 outstanding, ch0 hit at 0x000041 → served with mem_data=0x0101; ch2 miss → mem_miss=1, sdram_request stays low after its handshake.
- Invalidate ch1 mid-FILL → burst completes, busy=0, next ch1 request at 0x001000 misses and issues a new burst.
- Assert reset during FILL, then drive stray rvalid/complete → no valid bits set; first request after reset misses.

Source files
------------

// File: rtl/audio_sample_cache.sv
// audio_sample_cache: per-channel single-line sample cache feeding the mixer from SDRAM bursts
module audio_sample_cache #(
  parameter int NUM_CHANNELS = 8,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_WIDTH = 26,
  localparam int CW = $clog2(NUM_CHANNELS),
  localparam int OB = $clog2(LINE_WORDS) + 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_request,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [CW-1:0]         mem_channel,
  input  logic                  mem_mode16,
  output logic                  mem_valid,
  output logic [15:0]           mem_data,
  output logic                  mem_miss,
  input  logic                  invalidate,
  input  logic [CW-1:0]         inv_channel,
  output logic                  busy,
  output logic                  sdram_request,
  input  logic                  sdram_ready,
  output logic [ADDR_WIDTH-1:0] sdram_address,
  input  logic                  sdram_rvalid,
  input  logic [ADDR_WIDTH-1:0] sdram_raddress,
  input  logic [31:0]           sdram_rdata,
  input  logic                  sdram_complete
);
  localparam int TW = ADDR_WIDTH - OB;
  localparam int WB = OB - 2;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t state;
  logic [NUM_CHANNELS-1:0] valid;
  logic [TW-1:0] tag [NUM_CHANNELS];
  logic [31:0] line [NUM_CHANNELS*LINE_WORDS];
  logic [CW-1:0] fill_ch;
  logic [TW-1:0] fill_tag;
  logic drop;
  logic [31:0] rd_word;
  logic [1:0] rd_off;
  logic rd_mode16;
  logic hit, miss, wr;
  logic [7:0] rd_byte;
  logic [CW+WB-1:0] rd_idx, wr_idx;
  logic unused_bits;
  assign unused_bits = ^{sdram_raddress[ADDR_WIDTH-1:OB], sdram_raddress[1:0]};
  always_comb begin
    hit = mem_request && valid[mem_channel] && tag[mem_channel] == mem_address[ADDR_WIDTH-1:OB]
          && !(invalidate && inv_channel == mem_channel);
    miss = mem_request && !hit;
    wr = state == FILL && sdram_rvalid;
    rd_idx = {mem_channel, mem_address[OB-1:2]};
    wr_idx = {fill_ch, sdram_raddress[OB-1:2]};
    rd_byte = rd_word[{rd_off, 3'b000} +: 8];
    mem_data = rd_mode16 ? (rd_off[1] ? rd_word[31:16] : rd_word[15:0]) : {rd_byte, rd_byte};
    busy = state != IDLE;
  end
  // Line store kept separate so it maps onto a block RAM with a registered read port
  always_ff @(posedge clock) begin
    if (wr) line[wr_idx] <= sdram_rdata;
    if (reset) rd_word <= '0;
    else if (hit) rd_word <= line[rd_idx];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      mem_valid <= 1'b0;
      mem_miss <= 1'b0;
      sdram_request <= 1'b0;
      sdram_address <= '0;
      fill_ch <= '0;
      fill_tag <= '0;
      drop <= 1'b0;
      rd_off <= '0;
      rd_mode16 <= 1'b0;
    end else begin
      mem_valid <= hit;
      mem_miss <= miss;
      if (hit) begin
        rd_off <= mem_address[1:0];
        rd_mode16 <= mem_mode16;
      end
      case (state)
        IDLE: if (miss) begin
          fill_ch <= mem_channel;
          fill_tag <= mem_address[ADDR_WIDTH-1:OB];
          valid[mem_channel] <= 1'b0;
          sdram_address <= {mem_address[ADDR_WIDTH-1:OB], {OB{1'b0}}};
          sdram_request <= 1'b1;
          drop <= 1'b0;
          state <= REQ;
        end
        REQ: if (sdram_ready) begin
          sdram_request <= 1'b0;
          state <= FILL;
        end
        FILL: if (sdram_complete) begin
          tag[fill_ch] <= fill_tag;
          valid[fill_ch] <= !drop;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed last so an invalidate overrides a same-cycle fill completion on that channel
      if (invalidate) begin
        valid[inv_channel] <= 1'b0;
        if (state != IDLE && inv_channel == fill_ch) drop <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_cache.sv
// tb_audio_sample_cache: random and directed checks of the sample cache against a behavioural model
module tb_audio_sample_cache;
  logic clock = 0, reset = 1;
  logic mem_request = 0, mem_mode16 = 0, invalidate = 0;
  logic [25:0] mem_address = 0;
  logic [2:0] mem_channel = 0, inv_channel = 0;
  logic mem_valid, mem_miss, busy, sdram_request;
  logic [15:0] mem_data;
  logic [25:0] sdram_address;
  logic sdram_ready = 0, sdram_rvalid = 0, sdram_complete = 0;
  logic [25:0] sdram_raddress = 0;
  logic [31:0] sdram_rdata = 0;
  int n_chk = 0, n_fail = 0;

  audio_sample_cache dut (
    .clock(clock), .reset(reset), .mem_request(mem_request), .mem_address(mem_address),
    .mem_channel(mem_channel), .mem_mode16(mem_mode16), .mem_valid(mem_valid),
    .mem_data(mem_data), .mem_miss(mem_miss), .invalidate(invalidate),
    .inv_channel(inv_channel), .busy(busy), .sdram_request(sdram_request),
    .sdram_ready(sdram_ready), .sdram_address(sdram_address), .sdram_rvalid(sdram_rvalid),
    .sdram_raddress(sdram_raddress), .sdram_rdata(sdram_rdata), .sdram_complete(sdram_complete)
  );

  always #5 clock = ~clock;

  // behavioural model
  logic [7:0] m_valid;
  logic [19:0] m_tag [8];
  logic [31:0] m_line [8][16];
  int phase;
  logic [2:0] f_ch;
  logic [19:0] f_tag;
  logic drop;
  logic e_valid, e_miss, e_req;
  logic [15:0] e_data;
  logic [25:0] e_addr;
  // SDRAM responder
  logic rs_busy = 0;
  logic [25:0] rs_base;
  int rs_cnt;

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    return 32'h03020100 + 32'(a[5:2]) * 32'h04040404 + 32'(a[25:6] ^ 20'h1) * 32'h9E3779B1;
  endfunction

  function automatic logic [15:0] extract(input logic [31:0] w, input logic [1:0] off, input logic m16);
    logic [7:0] b;
    b = 8'(w >> (8 * off));
    return m16 ? (off[1] ? w[31:16] : w[15:0]) : {b, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_sdram();
    sdram_ready = rs_busy ? 1'b0 : 1'($urandom % 2);
    if (rs_busy && rs_cnt < 16) begin
      sdram_rvalid = 1'($urandom % 2);
      sdram_raddress = rs_base + 26'(4 * rs_cnt);
      sdram_rdata = mem_word(sdram_raddress);
      sdram_complete = 0;
    end else if (rs_busy) begin
      sdram_rvalid = 0;
      sdram_complete = 1;
    end else begin
      sdram_rvalid = ($urandom % 8) == 0;
      sdram_raddress = 26'($urandom);
      sdram_rdata = $urandom;
      sdram_complete = ($urandom % 16) == 0;
    end
  endtask

  task automatic cycle();
    logic hs, hit;
    int ch, old_phase;
    logic [25:0] a;
    drive_sdram();
    hs = sdram_request && sdram_ready;
    @(posedge clock);
    if (reset) begin
      m_valid = 0; phase = 0; drop = 0; f_ch = 0; f_tag = 0;
      e_valid = 0; e_miss = 0; e_req = 0; e_data = 0; e_addr = 0;
    end else begin
      ch = int'(mem_channel);
      a = mem_address;
      hit = mem_request && m_valid[ch] && m_tag[ch] == a[25:6] && !(invalidate && inv_channel == mem_channel);
      e_valid = hit;
      e_miss = mem_request && !hit;
      if (hit) e_data = extract(m_line[ch][a[5:2]], a[1:0], mem_mode16);
      old_phase = phase;
      if (phase == 0 && e_miss) begin
        f_ch = mem_channel; f_tag = a[25:6]; m_valid[ch] = 0;
        e_addr = {a[25:6], 6'b0}; e_req = 1; drop = 0; phase = 1;
      end else if (phase == 1 && sdram_ready) begin
        e_req = 0; phase = 2;
      end else if (phase == 2) begin
        if (sdram_rvalid) m_line[f_ch][sdram_raddress[5:2]] = sdram_rdata;
        if (sdram_complete) begin
          m_tag[f_ch] = f_tag; m_valid[f_ch] = !drop; phase = 0;
        end
      end
      if (invalidate) begin
        m_valid[inv_channel] = 0;
        if (old_phase != 0 && inv_channel == f_ch) drop = 1;
      end
    end
    if (rs_busy) begin
      if (sdram_rvalid) rs_cnt++;
      if (sdram_complete) rs_busy = 0;
    end else if (hs) begin
      rs_busy = 1; rs_base = sdram_address; rs_cnt = 0;
    end
    #1;
    chk("mem_valid", 32'(mem_valid), 32'(e_valid));
    chk("mem_miss", 32'(mem_miss), 32'(e_miss));
    chk("mem_data", 32'(mem_data), 32'(e_data));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("sdram_request", 32'(sdram_request), 32'(e_req));
    chk("sdram_address", 32'(sdram_address), 32'(e_addr));
  endtask

  task automatic req(input int ch, input logic [25:0] a, input logic m16);
    mem_request = 1; mem_channel = 3'(ch); mem_address = a; mem_mode16 = m16;
    cycle();
    mem_request = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) cycle();
    chk("wait_idle", 32'(busy), 0);
  endtask

  task automatic wait_fill();
    for (int i = 0; i < 300 && !(busy && !sdram_request); i++) cycle();
    chk("reach_fill", 32'({busy, sdram_request}), 32'b10);
  endtask

  initial begin
    repeat (3) cycle();
    reset = 0;
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_miss", 32'(mem_miss), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sreq", 32'(sdram_request), 0);
    chk("rst_saddr", 32'(sdram_address), 0);
    req(0, 26'h40, 0);
    chk("first_miss", 32'(mem_miss), 1);
    chk("first_sreq", 32'(sdram_request), 1);
    chk("first_saddr", 32'(sdram_address), 32'h40);
    wait_idle();
    req(0, 26'h45, 0);
    chk("hit8_valid", 32'(mem_valid), 1);
    chk("hit8_data", 32'(mem_data), 32'h0505);
    req(0, 26'h46, 1);
    chk("hit16_data", 32'(mem_data), 32'h0706);
    req(0, 26'h47, 1);
    chk("hit16_odd", 32'(mem_data), 32'h0706);
    req(1, 26'h1000, 0);
    wait_fill();
    req(0, 26'h41, 0);
    chk("busy_hit_valid", 32'(mem_valid), 1);
    chk("busy_hit_data", 32'(mem_data), 32'h0101);
    req(2, 26'h2000, 0);
    chk("busy_miss", 32'(mem_miss), 1);
    chk("busy_no_sreq", 32'(sdram_request), 0);
    invalidate = 1; inv_channel = 1;
    cycle();
    invalidate = 0;
    wait_idle();
    req(1, 26'h1000, 0);
    chk("drop_miss", 32'(mem_miss), 1);
    chk("drop_sreq", 32'(sdram_request), 1);
    chk("drop_saddr", 32'(sdram_address), 32'h1000);
    wait_idle();
    req(3, 26'h3000, 1);
    wait_fill();
    reset = 1;
    cycle();
    reset = 0;
    for (int i = 0; i < 300 && rs_busy; i++) cycle();
    chk("stale_busy", 32'(busy), 0);
    req(0, 26'h40, 0);
    chk("post_rst_miss", 32'(mem_miss), 1);
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      mem_request = 1'($urandom % 2);
      mem_channel = 3'($urandom % 4);
      mem_address = 26'((($urandom % 3) << 12) | ($urandom & 63));
      mem_mode16 = 1'($urandom % 2);
      invalidate = ($urandom % 32) == 0;
      inv_channel = 3'($urandom % 4);
      cycle();
    end
    mem_request = 0; invalidate = 0;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
